pl_stage_elastic: RTL

Parametrised elastic pipeline-stage register, the next generation of the per-stage latches between IF/ID/EX/MEM/WB. Carries a DW-bit datapath payload and a CW-bit control field with a valid/ready handshake, replacing the plain WEN/flush latch. In SKID mode a second entry absorbs one beat so `in_ready` is registered and the ready path is cut. Flush kills in-flight control without disturbing data. A saturating bubble counter is provided for performance monitoring.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/pl_stage_elastic.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t    : native datapath word
//   plstate_t : occupancy of an elastic pipeline-stage register
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    PL_EMPTY,
    PL_ONE,
    PL_TWO
  } plstate_t;

endpackage

// File: rtl/pl_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake.
// Carries a DW-bit payload and a CW-bit control field. SKID=1 adds a second
// entry so in_ready comes straight from the state register; SKID=0 is a single
// entry with a combinational in_ready. Flush kills valid and control bits but
// leaves data untouched. bubble_cnt counts cycles with out_valid=0 while
// downstream is ready, saturating at all-ones.
//   CLK, nRST            : clock, asynchronous active-low reset
//   flush                : invalidate every held entry this edge
//   in_valid/in_ready    : upstream handshake, with in_ctrl/in_data
//   out_valid/out_ready  : downstream handshake, with out_ctrl/out_data
//   bubble_cnt           : saturating bubble counter
module pl_stage_elastic
  import cpu_types_pkg::*;
#(
  parameter int unsigned DW   = $bits(word_t),
  parameter int unsigned CW   = 2,
  parameter bit          SKID = 1'b1,
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_ctrl,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_ctrl,
  output logic [DW-1:0]   out_data,
  output logic [CNTW-1:0] bubble_cnt
);

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          head_q, head_d;
  entry_t          beat;
  logic            accept, consume;
  logic [CNTW-1:0] bubble_q, bubble_d;

  assign beat    = {1'b1, in_ctrl, in_data};
  assign accept  = in_valid && in_ready;
  assign consume = head_q.vld && out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q   <= '0;
      bubble_q <= '0;
    end else begin
      head_q   <= head_d;
      bubble_q <= bubble_d;
    end
  end

  if (SKID) begin : g_skid
    plstate_t state_q, state_d;
    entry_t   skid_q, skid_d;

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        state_q <= PL_EMPTY;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        skid_q  <= skid_d;
      end
    end

    always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
        PL_EMPTY: begin
          if (accept) begin
            head_d  = beat;
            state_d = PL_ONE;
          end
        end
        PL_ONE: begin
          if (accept && !consume) begin
            skid_d  = beat;
            state_d = PL_TWO;
          end else if (consume && !accept) begin
            head_d.vld = 1'b0;
            state_d    = PL_EMPTY;
          end else if (consume && accept) begin
            head_d = beat;
          end
        end
        PL_TWO: begin
          if (consume) begin
            head_d     = skid_q;
            skid_d.vld = 1'b0;
            state_d    = PL_ONE;
          end
        end
        default: state_d = PL_EMPTY;
      endcase
      // Flush overrides whatever the handshake decided; data fields keep
      // their previous contents on purpose.
      if (flush) begin
        state_d     = PL_EMPTY;
        head_d.vld  = 1'b0;
        head_d.ctrl = '0;
        skid_d.vld  = 1'b0;
        skid_d.ctrl = '0;
      end
    end

    assign in_ready = (state_q != PL_TWO);
  end else begin : g_single
    always_comb begin
      head_d = head_q;
      if (accept) begin
        head_d = beat;
      end else if (consume) begin
        head_d.vld = 1'b0;
      end
      if (flush) begin
        head_d.vld  = 1'b0;
        head_d.ctrl = '0;
      end
    end

    assign in_ready = !head_q.vld || out_ready;
  end

  always_comb begin
    bubble_d = bubble_q;
    if (!head_q.vld && out_ready && !flush && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNTW'(1);
    end
  end

  assign out_valid  = head_q.vld;
  assign out_ctrl   = head_q.vld ? head_q.ctrl : '0;
  assign out_data   = head_q.data;
  assign bubble_cnt = bubble_q;

endmodule
